receptor_uart_muestras: RTL and testbench
=========================================

# receptor_uart_muestras

Serial front end of the filter path: an 8N1 UART receiver with 16x oversampling that assembles two consecutive bytes (low byte first) into one `ANCHO`-bit sample. It delivers each sample on `Uk` with a one-cycle `rx_done_tick`, the exact pair the filter FSM consumes to start a computation. It recovers from glitches, framing errors and lost bytes without host intervention.

## Interface
- `CLK_DIV`, 326: clocks per oversample tick (50 MHz / (9600·16) ≈ 326); legal 2..65535.
- `ANCHO`, 16: sample width; legal 9..16; equals the filter's `ancho`.
- `TIMEOUT_TICKS`, 320: oversample ticks of line idle after a low byte before that byte is discarded.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `Uk`  out  ANCHO  last assembled sample; holds between updates.
- `rx_done_tick`  out  1  one-cycle pulse: new `Uk` valid.
- `error_trama`  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized `rx_s`.
- Tick generator: free-running counter 0..CLK_DIV-1; `s_tick` high one clock when count = CLK_DIV-1; never stops or resets except on `reset`.
- Bit FSM, counters `s` (4 bit, counts s_ticks) and `n` (3 bit, bit index):
  - IDLE: `rx_s`=0 -> START, s=0.
  - START: on s_tick, s++; at s=7: `rx_s`=0 -> DATA, s=0, n=0; `rx_s`=1 -> IDLE (glitch, nothing reported).
  - DATA: on s_tick, s++; at s=15 shift `rx_s` into byte register LSB-first, s=0; after n=7 -> STOP, else n++.
  - STOP: on s_tick, s++; at s=15: `rx_s`=1 -> byte valid; `rx_s`=0 -> `error_trama` pulse, byte discarded, assembly index cleared. Both -> IDLE.
- Word assembly, index `sel` (1 bit):
  - valid byte, sel=0: store as low byte, sel=1.
  - valid byte, sel=1: `Uk` <= {byte[ANCHO-9:0], low}; high byte bits above ANCHO-9 are ignored; pulse `rx_done_tick`; sel=0.
- Timeout: counter of s_ticks runs only while sel=1 and FSM in IDLE; cleared on leaving IDLE or sel=0; reaching TIMEOUT_TICKS sets sel=0 (low byte dropped, no error pulse).
- No flow control: a new word overwrites `Uk`; downstream must latch on the tick.

## Timing
- Reset values: `Uk`=0, `rx_done_tick`=0, `error_trama`=0, FSM IDLE, sel=0, s=n=0, tick counter 0, synchronizer 1. Reset mid-frame aborts the frame and drops any stored low byte; reception restarts on the next falling edge after release.
- `rx_done_tick` and the new `Uk` appear together, registered, on the clock edge after the stop-bit-center s_tick; pulse width exactly 1 clk.
- `error_trama` same timing as `rx_done_tick`; never both in one cycle.
- Start-edge detection latency: 2 clk (synchronizer) plus up to 1 tick period.
- Sample-to-output latency: ~9.5 bit times from start edge of the high byte + 3 clk.
- Back-to-back frames (stop bit directly followed by start) are received; FSM returns to IDLE at stop center, leaving half a bit to detect the next edge.
- Start pulse shorter than 8 ticks: rejected. Timeout boundary: expiry on the same tick a start edge is seen -> start wins, counter clears, low byte kept.

## Test plan
- CLK_DIV=4, bytes 0x34 then 0x12 -> `Uk`=0x1234, one `rx_done_tick`, `error_trama` never high.
- ANCHO=12, bytes 0xCD, 0xFB -> `Uk`=0xBCD (upper nibble of high byte ignored).
- 3-tick low glitch on idle line, then bytes 0x01,0x00 -> no output from glitch; `Uk`=0x0001.
- Second byte sent with stop bit 0 -> `error_trama` pulse, no `rx_done_tick`, `Uk` unchanged; then 0x78,0x56 -> `Uk`=0x5678.
- One byte 0xAA, idle 400 ticks, then 0xCD,0xAB -> `Uk`=0xABCD (0xAA discarded); repeat with 200-tick gap -> `Uk`=0xCDAA.
- Assert `reset` during DATA of the high byte -> all outputs 0; next pair 0x22,0x11 -> `Uk`=0x1122; 4 back-to-back words -> 4 ticks, correct values.

Source files
------------

// File: rtl/receptor_uart_muestras.sv
// 8N1 UART receiver, 16x oversampled, that pairs consecutive bytes (low first)
// into one ANCHO-bit sample with a single-cycle rx_done_tick.
module receptor_uart_muestras #(
  parameter int CLK_DIV       = 326,
  parameter int ANCHO         = 16,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [ANCHO-1:0] Uk,
  output logic             rx_done_tick,
  output logic             error_trama
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_meta_q, rx_s_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_tick;
  logic [1:0]       state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       low_q, low_d;
  logic             sel_q, sel_d;
  logic [TW-1:0]    to_q, to_d;
  logic [ANCHO-1:0] uk_q, uk_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Free-running oversample tick; independent of line activity.
  assign s_tick = (cnt_q == CW'(CLK_DIV - 1));
  assign cnt_d  = s_tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    low_d   = low_q;
    sel_d   = sel_q;
    to_d    = to_q;
    uk_d    = uk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            s_d = '0;
            n_d = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[7:1]};
            if (n_q == 3'd7) state_d = STOP;
            else             n_d = n_q + 3'd1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            state_d = IDLE;
            s_d     = '0;
            if (!rx_s_q) begin
              err_d = 1'b1;
              sel_d = 1'b0;
            end else if (!sel_q) begin
              low_d = b_q;
              sel_d = 1'b1;
            end else begin
              uk_d   = {b_q[ANCHO-9:0], low_q};
              done_d = 1'b1;
              sel_d  = 1'b0;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
    endcase

    // A start edge seen in IDLE beats a simultaneous expiry: the low byte survives.
    if (state_q != IDLE || !sel_q || !rx_s_q) begin
      to_d = '0;
    end else if (s_tick) begin
      if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
        to_d  = '0;
        sel_d = 1'b0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      low_q     <= '0;
      sel_q     <= 1'b0;
      to_q      <= '0;
      uk_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      low_q     <= low_d;
      sel_q     <= sel_d;
      to_q      <= to_d;
      uk_q      <= uk_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign Uk           = uk_q;
  assign rx_done_tick = done_q;
  assign error_trama  = err_q;

endmodule

// File: tb/tb_receptor_uart_muestras.sv
// Bench for receptor_uart_muestras: 16-bit and 12-bit receivers share one line;
// a byte-level model predicts the words, framing errors and timeouts.
module tb_receptor_uart_muestras;

  localparam int CLK_DIV = 4;
  localparam int TO      = 320;
  localparam int BIT_CLK = 16 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] uk16;
  logic [11:0] uk12;
  logic        d16, e16, d12, e12;

  always #5 clk = ~clk;

  receptor_uart_muestras #(.CLK_DIV(CLK_DIV), .ANCHO(16), .TIMEOUT_TICKS(TO)) dut16 (
    .clk(clk), .reset(reset), .rx(rx), .Uk(uk16), .rx_done_tick(d16), .error_trama(e16));
  receptor_uart_muestras #(.CLK_DIV(CLK_DIV), .ANCHO(12), .TIMEOUT_TICKS(TO)) dut12 (
    .clk(clk), .reset(reset), .rx(rx), .Uk(uk12), .rx_done_tick(d12), .error_trama(e12));

  int tests = 0;
  int fails = 0;

  // Observations
  logic [15:0] obs16_q[$];
  logic [15:0] obs12_q[$];
  int obs_err = 0, obs_err12 = 0, wide = 0, overlap = 0;
  logic prev_d16 = 1'b0;

  always @(negedge clk) begin
    if (d16) begin
      obs16_q.push_back(uk16);
      if (prev_d16) wide <= wide + 1;
    end
    if (d12) obs12_q.push_back({4'h0, uk12});
    if (e16) obs_err <= obs_err + 1;
    if (e12) obs_err12 <= obs_err12 + 1;
    if ((d16 && e16) || (d12 && e12)) overlap <= overlap + 1;
    prev_d16 <= d16;
  end

  // Reference model: byte pairing by sequence, timeout by idle time
  logic [15:0] exp16_q[$];
  logic [15:0] exp12_q[$];
  int          exp_err = 0;
  bit          msel = 1'b0;
  logic [7:0]  mlow = 8'h00;
  logic [15:0] mlast16 = 16'h0;
  logic [15:0] mlast12 = 16'h0;
  int          idle_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT_CLK);
    end
    if (ok) begin
      rx = 1'b1;
      wait_clk(BIT_CLK);
    end else begin
      // Low through the stop-bit center only, so the tail cannot look like a start.
      rx = 1'b0;
      wait_clk(40);
      rx = 1'b1;
      wait_clk(BIT_CLK - 40);
    end
    idle_acc = 8;
    if (!ok) begin
      exp_err++;
      msel = 1'b0;
    end else if (!msel) begin
      mlow = b;
      msel = 1'b1;
    end else begin
      mlast16 = {b, mlow};
      mlast12 = {4'h0, b[3:0], mlow};
      exp16_q.push_back(mlast16);
      exp12_q.push_back(mlast12);
      msel = 1'b0;
    end
  endtask

  task automatic gap(input int ticks);
    rx = 1'b1;
    wait_clk(ticks * CLK_DIV);
    idle_acc += ticks;
    if (msel && idle_acc >= TO) msel = 1'b0;
  endtask

  task automatic check_words(input string tag);
    int n;
    wait_clk(4);
    chk({tag, " count16"}, obs16_q.size(), exp16_q.size());
    chk({tag, " count12"}, obs12_q.size(), exp12_q.size());
    n = (obs16_q.size() < exp16_q.size()) ? obs16_q.size() : exp16_q.size();
    for (int i = 0; i < n; i++) chk({tag, " word16"}, obs16_q[i], exp16_q[i]);
    n = (obs12_q.size() < exp12_q.size()) ? obs12_q.size() : exp12_q.size();
    for (int i = 0; i < n; i++) chk({tag, " word12"}, obs12_q[i], exp12_q[i]);
    chk({tag, " errors"}, obs_err, exp_err);
    chk({tag, " errors12"}, obs_err12, exp_err);
    chk({tag, " Uk16"}, uk16, mlast16);
    chk({tag, " Uk12"}, {4'h0, uk12}, mlast12);
    obs16_q.delete();
    obs12_q.delete();
    exp16_q.delete();
    exp12_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    wait_clk(5);
    chk("reset Uk16", uk16, 16'h0);
    chk("reset Uk12", {4'h0, uk12}, 16'h0);
    chk("reset done", {d16, d12}, 2'b00);
    chk("reset err", {e16, e12}, 2'b00);
    reset = 1'b0;
    gap(20);

    // Basic pair, then high-byte truncation for the 12-bit instance
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1); gap(10);
    check_words("pair1234");
    send_byte(8'hCD, 1'b1); send_byte(8'hFB, 1'b1); gap(10);
    check_words("pairFBCD");

    // Short low glitch must be rejected
    rx = 1'b0; wait_clk(3 * CLK_DIV); rx = 1'b1;
    gap(30);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); gap(10);
    check_words("glitch");

    // Framing error on the high byte drops the pair
    send_byte(8'h99, 1'b1); send_byte(8'h55, 1'b0); gap(20);
    check_words("framing");
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); gap(10);
    check_words("after_err");

    // Timeout drops a lone low byte; a shorter gap keeps it
    send_byte(8'hAA, 1'b1); gap(400);
    send_byte(8'hCD, 1'b1); send_byte(8'hAB, 1'b1); gap(10);
    check_words("timeout400");
    send_byte(8'hAA, 1'b1); gap(200);
    send_byte(8'hCD, 1'b1); gap(10);
    check_words("timeout200");

    // Reset in the middle of the high byte
    send_byte(8'h10, 1'b1);
    rx = 1'b0; wait_clk(BIT_CLK);
    rx = 1'b1; wait_clk(3 * BIT_CLK);
    reset = 1'b1;
    wait_clk(3);
    chk("midreset Uk16", uk16, 16'h0);
    chk("midreset Uk12", {4'h0, uk12}, 16'h0);
    chk("midreset flags", {d16, e16, d12, e12}, 4'b0000);
    msel = 1'b0; mlast16 = 16'h0; mlast12 = 16'h0;
    rx = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    gap(20);
    send_byte(8'h22, 1'b1); send_byte(8'h11, 1'b1);
    for (int w = 0; w < 4; w++) begin
      send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b1);
    end
    gap(10);
    check_words("backtoback");

    // Random bytes, random short gaps, occasional framing errors
    for (int k = 0; k < 14; k++) begin
      send_byte(8'($urandom), $urandom_range(0, 5) != 0);
      gap($urandom_range(0, 40));
    end
    gap(10);
    check_words("random");

    chk("pulse width", wide, 0);
    chk("done/err overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
